// File: rtl/adder_rr_sequencer.sv
// Round-robin arbitrated adder: requesters share one 4-bit add slice, WIDTH/4 beats per sum.
// Optional per-requester carry-in port enabled by defining ADDER_RR_SEQUENCER_CIN_EN.
module adder_rr_sequencer #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 16,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef ADDER_RR_SEQUENCER_CIN_EN
    input  logic [NREQ-1:0]       req_cin,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    localparam int NBEAT = WIDTH / 4;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic [BW-1:0]    beat;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             init_carry;
    logic             handshake;
    logic [4:0]       slice;
    logic [WIDTH+3:0] sum_shift;
    int               idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        req_ready   = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        sel_a       = '0;
        sel_b       = '0;
        init_carry  = 1'b0;
        idx         = 0;
        // Search starts just past the last winner and wraps, so nobody wins twice while others wait.
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_found && grant_id == IDW'(i)) begin
                req_ready[i] = (state == IDLE) && !rst;
                sel_a        = req_a[i*WIDTH +: WIDTH];
                sel_b        = req_b[i*WIDTH +: WIDTH];
`ifdef ADDER_RR_SEQUENCER_CIN_EN
                init_carry   = req_cin[i];
`endif
            end
        end
    end

    assign handshake = |(req_valid & req_ready);

    // The single shared slice always works on the low nibble; operands shift down each beat.
    assign slice     = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry};
    assign sum_shift = {slice[3:0], sum_q};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            carry      <= 1'b0;
            sum_q      <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            beat       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        carry      <= init_carry;
                        beat       <= '0;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    sum_q <= sum_shift[WIDTH+3:4];
                    carry <= slice[4];
                    beat  <= beat + 1'b1;
                    if (beat == BW'(NBEAT - 1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == RESP) && !rst;
    assign busy      = (state != IDLE) && !rst;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_rr_sequencer.sv
// Self-checking bench for adder_rr_sequencer (NREQ=2, WIDTH=16): directed vectors plus a
// per-cycle behavioural model of arbitration, latency and the arithmetic result.
module tb_adder_rr_sequencer;

    localparam int NREQ  = 2;
    localparam int WIDTH = 16;
    localparam int NBEAT = WIDTH / 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [0:0]            rsp_id;
    logic                  busy;

    adder_rr_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: an accepted request owes a response exactly NBEAT+1 cycles later, holding until taken.
    bit               check_en = 1'b0;
    bit               m_busy   = 1'b0;
    int               m_left   = 0;
    int               m_last   = NREQ - 1;
    int               m_id     = 0;
    logic [WIDTH-1:0] m_a      = '0;
    logic [WIDTH-1:0] m_b      = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        logic [WIDTH:0]  full;
        int              idx;
        int              gi;
        if (check_en) begin
            exp_ready = '0;
            gi        = 0;
            if (!rst && !m_busy) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (req_valid[idx] && exp_ready == '0) exp_ready[idx] = 1'b1;
                end
            end
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, !rst && m_busy);
            check("rsp_valid", rsp_valid, !rst && m_busy && m_left == 0);
            if (!rst && m_busy && m_left == 0) begin
                full = {1'b0, m_a} + {1'b0, m_b};
                check("rsp_sum", rsp_sum, full[WIDTH-1:0]);
                check("rsp_cout", rsp_cout, full[WIDTH]);
                check("rsp_id", rsp_id, m_id);
            end
            if (rst) begin
                m_busy = 1'b0;
                m_last = NREQ - 1;
            end else if (!m_busy) begin
                if (exp_ready != '0) begin
                    for (int k = 0; k < NREQ; k++) if (exp_ready[k]) gi = k;
                    m_a    = req_a[gi*WIDTH +: WIDTH];
                    m_b    = req_b[gi*WIDTH +: WIDTH];
                    m_id   = gi;
                    m_last = gi;
                    m_busy = 1'b1;
                    m_left = NBEAT;
                end
            end else if (m_left > 0) begin
                m_left--;
            end else if (rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction with literal expectations; hold>0 keeps rsp_ready low for that many extra cycles.
    task automatic run_txn(input string tag, input logic [1:0] valid,
                           input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1,
                           input int exp_id, input logic [15:0] exp_sum,
                           input logic exp_cout, input int hold);
        bit got;
        int lat;
        logic [15:0] held;
        req_valid = valid;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        rsp_ready = (hold == 0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                got = 1'b1;
                check({tag, "_grant"}, req_ready, 2'b01 << exp_id);
            end
            step();
        end
        check({tag, "_accepted"}, got, 1'b1);
        if (!got) return;
        req_a = ~req_a;
        req_b = ~req_b;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
            else step();
        end
        check({tag, "_latency"}, lat, NBEAT + 1);
        if (!got) return;
        held = rsp_sum;
        for (int i = 0; i < hold; i++) begin
            step();
            @(negedge clk);
            check({tag, "_hold_sum"}, rsp_sum, held);
            check({tag, "_hold_valid"}, rsp_valid, 1'b1);
        end
        if (hold > 0) begin
            step();
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        check({tag, "_sum"}, rsp_sum, exp_sum);
        check({tag, "_cout"}, rsp_cout, exp_cout);
        check({tag, "_id"}, rsp_id, exp_id);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit saw;
        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) step();
        check_en = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("reset_sum", rsp_sum, 16'h0000);
        check("reset_cout", rsp_cout, 1'b0);
        check("reset_id", rsp_id, 1'b0);
        check("reset_busy", busy, 1'b0);
        step();

        run_txn("basic",     2'b01, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 0, 16'h5555, 1'b0, 0);
        run_txn("ripple",    2'b01, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0, 16'h0000, 1'b1, 0);
        run_txn("req1",      2'b10, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1, 16'h0000, 1'b1, 0);
        run_txn("alt0",      2'b11, 16'h0F0F, 16'h0101, 16'h1111, 16'h2222, 0, 16'h1010, 1'b0, 0);
        run_txn("alt1",      2'b11, 16'h5555, 16'h5555, 16'hABCD, 16'h1111, 1, 16'hBCDE, 1'b0, 0);
        run_txn("alt2",      2'b11, 16'h7FFF, 16'h0001, 16'h0001, 16'h0001, 0, 16'h8000, 1'b0, 0);
        run_txn("alt3",      2'b11, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 1'b1, 0);
        req_valid = '0;
        step();
        run_txn("stall",     2'b01, 16'h0AAA, 16'h0555, 16'h0000, 16'h0000, 0, 16'h0FFF, 1'b0, 10);
        req_valid = '0;
        step();

        // Abort during beat 2 of ADD: no response may appear afterwards.
        req_valid = 2'b11;
        req_a     = {16'h1111, 16'h2222};
        req_b     = {16'h3333, 16'h4444};
        rsp_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) got = 1'b1;
            step();
        end
        check("abort_accepted", got, 1'b1);
        req_valid = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
            step();
        end
        check("abort_no_rsp", saw, 1'b0);
        run_txn("after_rst", 2'b11, 16'h00FF, 16'h0F01, 16'h1234, 16'h1234, 0, 16'h1000, 1'b0, 0);
        req_valid = '0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
